// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   RF_DW / RF_PW / RF_NRD : default data width, pointer width, read-port count
//   clr_state_t            : bulk-clear sequencer states
package rf_pkg;

  localparam int RF_DW  = 8;
  localparam int RF_PW  = 4;
  localparam int RF_NRD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/rf_clr_seq.sv
// Bulk-clear sequencer: sweeps a pointer across every register, one per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_req    : start request, sampled only in IDLE
//   busy       : high while sweeping (state CLEAR)
//   done       : one-cycle pulse after the last register is cleared (state DONE)
//   clr_we     : write strobe to the array (zero the register at clr_addr)
//   clr_addr   : register being cleared this cycle
//   state_dbg  : current sequencer state, for observation
// Handshake: clr_req is a level sampled at a clock edge while idle; once taken,
// busy stays high for exactly 2**PW cycles, then done pulses for one cycle.
// Requests seen while busy or done are dropped, never queued.
module rf_clr_seq
  import rf_pkg::*;
#(
  parameter int PW = RF_PW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          done,
  output logic          clr_we,
  output logic [PW-1:0] clr_addr,
  output clr_state_t    state_dbg
);

  localparam logic [PW-1:0] PTR_MAX = {PW{1'b1}};

  clr_state_t    state;
  logic [PW-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          // Full-width compare on the last register; the wrap of ptr is harmless.
          if (ptr == PTR_MAX) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CLEAR);
  assign done      = (state == DONE);
  assign clr_we    = busy;
  assign clr_addr  = ptr;
  assign state_dbg = state;

endmodule

// File: rtl/reg_file_mp.sv
// Parameterised register file with NRD combinational read ports, one write port,
// optional write-through bypass and a sequenced bulk clear.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (zeroes the array)
//   wr_en/wr_addr/dat_in : write port; ignored while the clear is sweeping
//   rd_addr[NRD]     : per-port read address
//   dat_out[NRD]     : per-port read data (0 cycle latency)
//   clr_req          : request a bulk clear of every register
//   clr_busy         : sweep in progress
//   clr_done         : one-cycle pulse when the sweep has finished
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DW     = RF_DW,
  parameter int PW     = RF_PW,
  parameter int NRD    = RF_NRD,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [PW-1:0] rd_addr [NRD],
  output logic [DW-1:0] dat_out [NRD],
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int DEPTH = 1 << PW;

  logic [DW-1:0] core [DEPTH];
  logic          clr_we;
  logic [PW-1:0] clr_addr;
  logic          wr_acc;
  clr_state_t    clr_state;

  rf_clr_seq #(.PW(PW)) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .busy      (clr_busy),
    .done      (clr_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state_dbg (clr_state)
  );

  // The sweep owns the write port; a user write during it is dropped entirely
  // (neither stored nor forwarded).
  assign wr_acc = wr_en & ~clr_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) core[i] <= '0;
    end else if (clr_we) begin
      core[clr_addr] <= '0;
    end else if (wr_acc) begin
      core[wr_addr] <= dat_in;
    end
  end

  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      if (BYPASS != 0) begin : g_byp
        assign dat_out[p] = (wr_acc && (wr_addr == rd_addr[p])) ? dat_in
                                                                 : core[rd_addr[p]];
      end else begin : g_nobyp
        assign dat_out[p] = core[rd_addr[p]];
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: one bypassing and one non-bypassing
// instance share all inputs and are checked against an array-based model.
module tb_reg_file_mp;

  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int NRD   = 2;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en = 1'b0;
  logic [PW-1:0] wr_addr = '0;
  logic [DW-1:0] dat_in = '0;
  logic [PW-1:0] rd_addr [NRD];
  logic          clr_req = 1'b0;
  logic [DW-1:0] dat_out_b [NRD];
  logic [DW-1:0] dat_out_n [NRD];
  logic          busy_b, done_b, busy_n, done_n;

  reg_file_mp #(.DW(DW), .PW(PW), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addr(rd_addr), .dat_out(dat_out_b), .clr_req(clr_req),
    .clr_busy(busy_b), .clr_done(done_b)
  );

  reg_file_mp #(.DW(DW), .PW(PW), .NRD(NRD), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addr(rd_addr), .dat_out(dat_out_n), .clr_req(clr_req),
    .clr_busy(busy_n), .clr_done(done_n)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int busy_seen = 0;

  logic [DW-1:0] mem [DEPTH];
  // -1: idle; 0..DEPTH-1: next register the sweep zeroes; DEPTH: done cycle
  int sweep = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_busy();
    return (sweep >= 0) && (sweep < DEPTH);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int p, input bit byp);
    if (byp && wr_en && !m_busy() && (wr_addr == rd_addr[p])) return dat_in;
    return mem[rd_addr[p]];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    sweep = -1;
  endtask

  task automatic model_edge();
    bit acc;
    acc = wr_en && !m_busy();
    if (acc) mem[wr_addr] = dat_in;
    if (m_busy()) begin
      mem[sweep] = '0;
      sweep++;
    end else if (sweep == DEPTH) begin
      sweep = -1;
    end else if (clr_req) begin
      sweep = 0;
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("byp_rd%0d", p), 32'(dat_out_b[p]), 32'(exp_rd(p, 1'b1)));
      check($sformatf("nob_rd%0d", p), 32'(dat_out_n[p]), 32'(exp_rd(p, 1'b0)));
    end
    check("byp_busy", 32'(busy_b), 32'(m_busy()));
    check("nob_busy", 32'(busy_n), 32'(m_busy()));
    check("byp_done", 32'(done_b), 32'(sweep == DEPTH));
    check("nob_done", 32'(done_n), 32'(sweep == DEPTH));
    if (done_b) done_seen++;
    if (busy_b) busy_seen++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    tick();
  endtask

  task automatic write_reg(input logic [PW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; dat_in = d;
    cycle();
    wr_en = 1'b0;
  endtask

  // Asserts reset between edges and checks the outputs fall without a clock.
  task automatic async_reset();
    wr_en = 1'b0;
    clr_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("rst_byp_rd%0d", p), 32'(dat_out_b[p]), 32'h0);
      check($sformatf("rst_nob_rd%0d", p), 32'(dat_out_n[p]), 32'h0);
    end
    check("rst_busy", 32'(busy_b), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rd_addr[0] = '0;
    rd_addr[1] = '0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset then read: core[3] = A5, reset mid-cycle clears it without a clock.
    write_reg(4'd3, 8'hA5);
    rd_addr[0] = 4'd3; rd_addr[1] = 4'd3;
    @(negedge clk);
    check("pre_rst_a5", 32'(dat_out_b[0]), 32'hA5);
    tick();
    async_reset();

    // Same-cycle write/read to address 5 on both ports.
    rd_addr[0] = 4'd5; rd_addr[1] = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd5; dat_in = 8'h3C;
    @(negedge clk);
    check_outputs();
    check("byp_same_p0", 32'(dat_out_b[0]), 32'h3C);
    check("byp_same_p1", 32'(dat_out_b[1]), 32'h3C);
    check("nob_same_p0", 32'(dat_out_n[0]), 32'h00);
    check("nob_same_p1", 32'(dat_out_n[1]), 32'h00);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check_outputs();
    check("byp_after", 32'(dat_out_b[1]), 32'h3C);
    check("nob_after", 32'(dat_out_n[0]), 32'h3C);
    tick();

    // Bulk clear with a dropped write, an ignored re-request and a DONE write.
    for (int i = 0; i < DEPTH; i++) write_reg(PW'(i), 8'hFF);
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      rd_addr[0] = PW'((c - 1) % DEPTH);
      rd_addr[1] = PW'(c % DEPTH);
      wr_en   = (c == 4) || (c == 17);
      wr_addr = (c == 4) ? 4'd2 : 4'd0;
      dat_in  = (c == 4) ? 8'h77 : 8'h11;
      clr_req = (c == 8);
      cycle();
    end
    wr_en = 1'b0;
    clr_req = 1'b0;
    check("clr_busy_len", 32'(busy_seen), 32'd16);
    check("clr_done_cnt", 32'(done_seen), 32'd1);
    rd_addr[0] = 4'd2; rd_addr[1] = 4'd0;
    @(negedge clk);
    check_outputs();
    check("drop_wr_addr2", 32'(dat_out_b[0]), 32'h00);
    check("done_wr_addr0", 32'(dat_out_n[1]), 32'h11);
    tick();

    // Reset during a sweep: no done pulse afterwards, everything reads 0.
    for (int i = 0; i < DEPTH; i++) write_reg(PW'(i), 8'(i + 8'h40));
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int c = 1; c <= 6; c++) cycle();
    async_reset();
    done_seen = 0;
    for (int c = 0; c < 24; c++) begin
      rd_addr[0] = PW'((2 * c) % DEPTH);
      rd_addr[1] = PW'((2 * c + 1) % DEPTH);
      cycle();
    end
    check("midsweep_no_done", 32'(done_seen), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = PW'($urandom_range(0, DEPTH - 1));
      dat_in     = DW'($urandom_range(0, 255));
      rd_addr[0] = ($urandom_range(0, 3) == 0) ? wr_addr : PW'($urandom_range(0, DEPTH - 1));
      rd_addr[1] = ($urandom_range(0, 3) == 0) ? wr_addr : PW'($urandom_range(0, DEPTH - 1));
      clr_req    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
